branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 186 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks in-flight BTB predictions in a small FIFO, resolves them in
// program order, and issues front-end redirects and BTB updates. Optional stats: BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned PC_BITS    = 11,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_valid,
    input  logic [PC_BITS-1:0]    pred_pc,
    input  logic                  pred_hit,
    input  logic [PC_BITS-1:0]    pred_target,
    output logic                  pred_ready,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [PC_BITS-1:0]    res_target,
    output logic                  btb_wr_enable,
    output logic [PC_BITS-1:0]    btb_new_pc_fetch,
    output logic [PC_BITS-1:0]    btb_new_pc_target,
    output logic                  redirect,
    output logic [PC_BITS-1:0]    redirect_pc,
    output logic [DEPTH_LOG2:0]   fifo_count,
`ifdef BRU_STATS_EN
    output logic [15:0]           stat_resolved,
    output logic [15:0]           stat_mispredicts,
`endif
    output logic                  res_error
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = DEPTH_LOG2;

    typedef struct packed {
        logic [PC_BITS-1:0] pc;
        logic               hit;
        logic [PC_BITS-1:0] target;
    } pred_entry_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    pred_entry_t        mem [DEPTH];
    pred_entry_t        head;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_d;
    logic               in_run;
    logic               do_res;
    logic               do_enq;
    logic               mispredict;
    logic               need_wr;
    logic [PC_BITS-1:0] fix_pc;
    logic               ready_d;
    logic               err_d;
    logic [PC_BITS-1:0] rpc_d;
    logic [PC_BITS-1:0] fetch_d;
    logic [PC_BITS-1:0] tgt_d;

    // Classify the oldest entry against the resolution and decide FIFO traffic.
    always_comb begin
        head       = mem[rd_ptr_q];
        in_run     = (state_q == ST_RUN);
        do_res     = in_run && res_valid && (fifo_count != '0);
        mispredict = 1'b0;
        need_wr    = 1'b0;
        fix_pc     = res_target;
        if (do_res) begin
            if (res_taken) begin
                if (!head.hit || (head.target != res_target)) begin
                    mispredict = 1'b1;
                    need_wr    = 1'b1;
                end
            end else if (head.hit) begin
                mispredict = 1'b1;
                fix_pc     = head.pc + PC_BITS'(1);
            end
        end
        // A flush in the same cycle drops the incoming prediction.
        do_enq = in_run && pred_valid && pred_ready && !mispredict;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (mispredict) state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // Next values for FIFO bookkeeping and the registered outputs.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = fifo_count;
        rpc_d    = redirect_pc;
        fetch_d  = btb_new_pc_fetch;
        tgt_d    = btb_new_pc_target;
        err_d    = res_error | (in_run && res_valid && (fifo_count == '0));
        if (mispredict) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rpc_d    = fix_pc;
            if (need_wr) begin
                fetch_d = head.pc;
                tgt_d   = res_target;
            end
        end else begin
            if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_res) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_enq, do_res})
                2'b10:   count_d = fifo_count + CNT_W'(1);
                2'b01:   count_d = fifo_count - CNT_W'(1);
                default: count_d = fifo_count;
            endcase
        end
        ready_d = (state_d == ST_RUN) && (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            fifo_count        <= '0;
            pred_ready        <= 1'b1;
            redirect          <= 1'b0;
            btb_wr_enable     <= 1'b0;
            redirect_pc       <= '0;
            btb_new_pc_fetch  <= '0;
            btb_new_pc_target <= '0;
            res_error         <= 1'b0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            fifo_count        <= count_d;
            pred_ready        <= ready_d;
            redirect          <= mispredict;
            btb_wr_enable     <= need_wr;
            redirect_pc       <= rpc_d;
            btb_new_pc_fetch  <= fetch_d;
            btb_new_pc_target <= tgt_d;
            res_error         <= err_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr_q] <= '{pc: pred_pc, hit: pred_hit, target: pred_target};
        end
    end

`ifdef BRU_STATS_EN
    // Saturating resolution and mispredict counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (do_res && (stat_resolved != 16'hFFFF)) begin
                stat_resolved <= stat_resolved + 16'd1;
            end
            if (mispredict && (stat_mispredicts != 16'hFFFF)) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit plus hand-written reset sequences.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [10:0] pred_pc;
    logic        pred_hit;
    logic [10:0] pred_target;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic [10:0] res_target;
    logic        btb_wr_enable;
    logic [10:0] btb_new_pc_fetch;
    logic [10:0] btb_new_pc_target;
    logic        redirect;
    logic [10:0] redirect_pc;
    logic [2:0]  fifo_count;
    logic        res_error;

    int n_chk;
    int n_pass;

    branch_resolve_unit #(.PC_BITS(11), .DEPTH_LOG2(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pred_valid        (pred_valid),
        .pred_pc           (pred_pc),
        .pred_hit          (pred_hit),
        .pred_target       (pred_target),
        .pred_ready        (pred_ready),
        .res_valid         (res_valid),
        .res_taken         (res_taken),
        .res_target        (res_target),
        .btb_wr_enable     (btb_wr_enable),
        .btb_new_pc_fetch  (btb_new_pc_fetch),
        .btb_new_pc_target (btb_new_pc_target),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .fifo_count        (fifo_count),
        .res_error         (res_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [10:0] ppc;
        logic        phit;
        logic [10:0] ptgt;
        logic        rv;
        logic        rt;
        logic [10:0] rtgt;
        logic        e_red;
        logic [10:0] e_rpc;
        logic        e_wr;
        logic [10:0] e_fetch;
        logic [10:0] e_tgt;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_err;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic red, input logic [10:0] rpc,
                           input logic wr, input logic [10:0] fetch, input logic [10:0] tgt,
                           input logic [2:0] cnt, input logic rdy, input logic err);
        chk({tag, ".redirect"},    32'(redirect),          32'(red));
        chk({tag, ".redirect_pc"}, 32'(redirect_pc),       32'(rpc));
        chk({tag, ".btb_wr"},      32'(btb_wr_enable),     32'(wr));
        chk({tag, ".new_fetch"},   32'(btb_new_pc_fetch),  32'(fetch));
        chk({tag, ".new_target"},  32'(btb_new_pc_target), 32'(tgt));
        chk({tag, ".count"},       32'(fifo_count),        32'(cnt));
        chk({tag, ".pred_ready"},  32'(pred_ready),        32'(rdy));
        chk({tag, ".res_error"},   32'(res_error),         32'(err));
    endtask

    task automatic idle_inputs();
        pred_valid  = 1'b0;
        pred_pc     = '0;
        pred_hit    = 1'b0;
        pred_target = '0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        res_target  = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        //            pv  ppc     hit ptgt    rv  rt  rtgt    red rpc     wr  fetch   tgt     cnt rdy err
        vecs[0]  = '{1, 11'h010, 0, 11'h000, 0, 0, 11'h000, 0, 11'h000, 0, 11'h000, 11'h000, 1, 1, 0};
        vecs[1]  = '{0, 11'h000, 0, 11'h000, 1, 1, 11'h040, 1, 11'h040, 1, 11'h010, 11'h040, 0, 0, 0};
        vecs[2]  = '{0, 11'h000, 0, 11'h000, 0, 0, 11'h000, 0, 11'h040, 0, 11'h010, 11'h040, 0, 1, 0};
        vecs[3]  = '{1, 11'h020, 1, 11'h080, 0, 0, 11'h000, 0, 11'h040, 0, 11'h010, 11'h040, 1, 1, 0};
        vecs[4]  = '{1, 11'h7FF, 1, 11'h123, 0, 0, 11'h000, 0, 11'h040, 0, 11'h010, 11'h040, 2, 1, 0};
        vecs[5]  = '{0, 11'h000, 0, 11'h000, 1, 1, 11'h080, 0, 11'h040, 0, 11'h010, 11'h040, 1, 1, 0};
        vecs[6]  = '{0, 11'h000, 0, 11'h000, 1, 0, 11'h000, 1, 11'h000, 0, 11'h010, 11'h040, 0, 0, 0};
        vecs[7]  = '{0, 11'h000, 0, 11'h000, 0, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 0, 1, 0};
        vecs[8]  = '{1, 11'h100, 0, 11'h000, 0, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 1, 1, 0};
        vecs[9]  = '{1, 11'h101, 0, 11'h000, 0, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 2, 1, 0};
        vecs[10] = '{1, 11'h102, 0, 11'h000, 0, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 3, 1, 0};
        vecs[11] = '{1, 11'h103, 0, 11'h000, 0, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 4, 0, 0};
        vecs[12] = '{1, 11'h1FF, 0, 11'h000, 0, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 4, 0, 0};
        vecs[13] = '{1, 11'h1FE, 0, 11'h000, 1, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 3, 1, 0};
        vecs[14] = '{1, 11'h104, 0, 11'h000, 1, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 3, 1, 0};
        vecs[15] = '{1, 11'h105, 0, 11'h000, 1, 0, 11'h000, 0, 11'h000, 0, 11'h010, 11'h040, 3, 1, 0};
        vecs[16] = '{1, 11'h106, 0, 11'h000, 1, 1, 11'h200, 1, 11'h200, 1, 11'h103, 11'h200, 0, 0, 0};
        vecs[17] = '{1, 11'h107, 0, 11'h000, 1, 1, 11'h200, 0, 11'h200, 0, 11'h103, 11'h200, 0, 1, 0};
        vecs[18] = '{0, 11'h000, 0, 11'h000, 1, 0, 11'h000, 0, 11'h200, 0, 11'h103, 11'h200, 0, 1, 1};
        vecs[19] = '{1, 11'h300, 0, 11'h000, 0, 0, 11'h000, 0, 11'h200, 0, 11'h103, 11'h200, 1, 1, 1};
        vecs[20] = '{0, 11'h000, 0, 11'h000, 0, 0, 11'h000, 0, 11'h200, 0, 11'h103, 11'h200, 1, 1, 1};

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 11'h000, 0, 11'h000, 11'h000, 0, 1, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            pred_valid  = vecs[i].pv;
            pred_pc     = vecs[i].ppc;
            pred_hit    = vecs[i].phit;
            pred_target = vecs[i].ptgt;
            res_valid   = vecs[i].rv;
            res_taken   = vecs[i].rt;
            res_target  = vecs[i].rtgt;
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].e_red, vecs[i].e_rpc, vecs[i].e_wr,
                    vecs[i].e_fetch, vecs[i].e_tgt, vecs[i].e_cnt, vecs[i].e_rdy, vecs[i].e_err);
        end

        // Asynchronous reset mid-run, asserted between clock edges.
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 11'h000, 0, 11'h000, 11'h000, 0, 1, 0);
        #2;
        rst_n = 1'b1;

        // First edge after release: no pulse, in-flight entry gone.
        @(posedge clk);
        #1;
        chk("post_rst.redirect", 32'(redirect), 32'd0);
        chk("post_rst.btb_wr",   32'(btb_wr_enable), 32'd0);
        chk("post_rst.count",    32'(fifo_count), 32'd0);

        // Resolving now must flag an error because the pre-reset entry was discarded.
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        res_target = 11'h055;
        @(posedge clk);
        #1;
        chk("post_rst.res_error", 32'(res_error), 32'd1);
        chk("post_rst.redirect2", 32'(redirect), 32'd0);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
